pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the in-order core pipeline (IF → ID → EX → WB).
- Covers the hazards that WB-to-EX operand forwarding cannot resolve:
  - load-use dependencies;
  - taken branch/jump redirects;
  - data-memory wait states;
  - multi-cycle MUL/DIV operations.
- Drives the PC, IF/ID, ID/EX and EX/WB register enables and flushes.
- Keeps a stall-cycle performance counter and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 42 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 55 +++++
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Core package for the in-order IF/ID/EX/WB pipeline. Holds the
//               base opcode map, the hazard-controller state encoding and the
//               operand-usage helpers shared with the forwarding logic.
// Contents    : OPCODE_* constants, hazard_state_e, uses_rs1(), uses_rs2()
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

   // RV32I base opcode map
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_R      = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   // Hazard controller state encoding
   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MEM_WAIT = 2'd1,
      HZ_MDU_WAIT = 2'd2
   } hazard_state_e;

   // rs1 is read by everything except the PC/immediate-only formats
   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !(opcode inside {OPCODE_JAL, OPCODE_LUI, OPCODE_AUIPC});
   endfunction

   // rs2 is read only by register-register, store and branch formats
   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode inside {OPCODE_R, OPCODE_STORE, OPCODE_BRANCH});
   endfunction

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Pipeline-to-hazard-controller bundle. The pipeline side
//               (master) supplies ID/EX status; the controller (slave)
//               returns register enables/flushes and status.
// Ports       : i_id_*, i_ex_*, i_dmem_ready, i_mdu_done   pipeline -> ctrl
//               o_*_stall, o_*_flush, o_mdu_busy,
//               o_mem_timeout, o_stall_cycles              ctrl -> pipeline
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       i_id_opcode;
   logic [4:0]       i_id_rs1;
   logic [4:0]       i_id_rs2;
   logic             i_ex_mem_read;
   logic [4:0]       i_ex_rd;
   logic             i_ex_mem_req;
   logic             i_dmem_ready;
   logic             i_ex_mdu_start;
   logic             i_mdu_done;
   logic             i_ex_redirect;

   logic             o_pc_stall;
   logic             o_if_id_stall;
   logic             o_if_id_flush;
   logic             o_id_ex_stall;
   logic             o_id_ex_flush;
   logic             o_ex_wb_stall;
   logic             o_mdu_busy;
   logic             o_mem_timeout;
   logic [CNT_W-1:0] o_stall_cycles;

   modport master (
      output i_id_opcode, i_id_rs1, i_id_rs2, i_ex_mem_read, i_ex_rd,
             i_ex_mem_req, i_dmem_ready, i_ex_mdu_start, i_mdu_done,
             i_ex_redirect,
      input  o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_stall,
             o_id_ex_flush, o_ex_wb_stall, o_mdu_busy, o_mem_timeout,
             o_stall_cycles
   );

   modport slave (
      input  i_id_opcode, i_id_rs1, i_id_rs2, i_ex_mem_read, i_ex_rd,
             i_ex_mem_req, i_dmem_ready, i_ex_mdu_start, i_mdu_done,
             i_ex_redirect,
      output o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_stall,
             o_id_ex_flush, o_ex_wb_stall, o_mdu_busy, o_mem_timeout,
             o_stall_cycles
   );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the IF/ID/EX/WB pipeline. Resolves
//               load-use, taken redirects, data-memory wait states and
//               multi-cycle MUL/DIV, counts stalled cycles and flags memory
//               accesses that wait too long.
// Ports       : i_clk    core clock
//               i_rst_n  synchronous active-low reset
//               bus      pipeline_hazard_ctrl_if.slave (status in, enables out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   pipeline_hazard_ctrl_if.slave       bus
);

   localparam int               c_TO_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(MEM_TIMEOUT);

   localparam logic [1:0] S_RUN      = HZ_RUN;
   localparam logic [1:0] S_MEM_WAIT = HZ_MEM_WAIT;
   localparam logic [1:0] S_MDU_WAIT = HZ_MDU_WAIT;

   logic [1:0]        r_state;
   logic [c_TO_W-1:0] r_to_cnt;
   logic              r_mem_timeout;
   logic [CNT_W-1:0]  r_stall_cycles;

   logic [1:0]        w_state_nxt;
   logic              w_load_use;
   logic              w_mem_hold;
   logic              w_freeze;
   logic [c_TO_W-1:0] w_to_inc;
   logic              w_pc_stall;
   logic              w_if_id_stall;
   logic              w_if_id_flush;
   logic              w_id_ex_stall;
   logic              w_id_ex_flush;
   logic              w_ex_wb_stall;
   logic              w_mdu_busy;

   // Load in EX whose destination is read by the ID instruction. x0 never
   // carries a real dependency.
   assign w_load_use = bus.i_ex_mem_read && (bus.i_ex_rd != 5'd0) &&
                       ((uses_rs1(bus.i_id_opcode) && (bus.i_ex_rd == bus.i_id_rs1)) ||
                        (uses_rs2(bus.i_id_opcode) && (bus.i_ex_rd == bus.i_id_rs2)));

   assign w_mem_hold = bus.i_ex_mem_req && !bus.i_dmem_ready;
   assign w_freeze   = w_mem_hold || bus.i_ex_mdu_start;

   // Saturating so a very long wait cannot wrap back below the threshold
   assign w_to_inc = (r_to_cnt == c_TO_MAX) ? r_to_cnt : r_to_cnt + c_TO_W'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_stall    = 1'b0;
      w_if_id_stall = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_stall = 1'b0;
      w_id_ex_flush = 1'b0;
      w_ex_wb_stall = 1'b0;
      w_mdu_busy    = 1'b0;

      case (r_state)
         S_RUN: begin
            if (w_freeze) begin
               // Whole pipe frozen; a pending redirect is retried once EX moves
               w_pc_stall    = 1'b1;
               w_if_id_stall = 1'b1;
               w_id_ex_stall = 1'b1;
               w_ex_wb_stall = 1'b1;
               w_state_nxt   = w_mem_hold ? S_MEM_WAIT : S_MDU_WAIT;
            end else if (bus.i_ex_redirect) begin
               // ID instruction is discarded, so its load-use is moot
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
               // One bubble; afterwards the load sits in WB and forwards
               w_pc_stall    = 1'b1;
               w_if_id_stall = 1'b1;
               w_id_ex_flush = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_stall = 1'b1;
            w_ex_wb_stall = 1'b1;
            if (bus.i_dmem_ready) begin
               w_state_nxt = S_RUN;
            end
         end
         S_MDU_WAIT: begin
            w_mdu_busy = 1'b1;
            if (bus.i_mdu_done) begin
               // Release in the done cycle so EX/WB latches the result
               w_state_nxt = S_RUN;
            end else begin
               w_pc_stall    = 1'b1;
               w_if_id_stall = 1'b1;
               w_id_ex_stall = 1'b1;
               w_ex_wb_stall = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase

      if (!i_rst_n) begin
         w_pc_stall    = 1'b0;
         w_if_id_stall = 1'b0;
         w_if_id_flush = 1'b0;
         w_id_ex_stall = 1'b0;
         w_id_ex_flush = 1'b0;
         w_ex_wb_stall = 1'b0;
         w_mdu_busy    = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state        <= S_RUN;
         r_to_cnt       <= '0;
         r_mem_timeout  <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_pc_stall) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end

         if (r_state == S_MEM_WAIT) begin
            if (w_to_inc == c_TO_MAX) begin
               r_mem_timeout <= 1'b1;
            end
            r_to_cnt <= bus.i_dmem_ready ? '0 : w_to_inc;
         end else begin
            r_to_cnt <= '0;
         end
      end
   end

   assign bus.o_pc_stall     = w_pc_stall;
   assign bus.o_if_id_stall  = w_if_id_stall;
   assign bus.o_if_id_flush  = w_if_id_flush;
   assign bus.o_id_ex_stall  = w_id_ex_stall;
   assign bus.o_id_ex_flush  = w_id_ex_flush;
   assign bus.o_ex_wb_stall  = w_ex_wb_stall;
   assign bus.o_mdu_busy     = w_mdu_busy;
   assign bus.o_mem_timeout  = r_mem_timeout;
   assign bus.o_stall_cycles = r_stall_cycles;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl: single-cycle
//               decision table, hand sequences for wait/timeout/MDU/reset,
//               and randomized traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   localparam int TB_TIMEOUT = 4;
   localparam int TB_CNT_W   = 32;

   logic i_clk = 1'b0;
   logic i_rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 i_clk = ~i_clk;

   pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT (TB_TIMEOUT),
      .CNT_W       (TB_CNT_W)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   // {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_wb_stall, busy}
   localparam logic [6:0] O_NONE   = 7'b000000_0;
   localparam logic [6:0] O_LU     = 7'b110010_0;
   localparam logic [6:0] O_RED    = 7'b001010_0;
   localparam logic [6:0] O_FREEZE = 7'b110101_0;
   localparam logic [6:0] O_MDUW   = 7'b110101_1;
   localparam logic [6:0] O_MDUD   = 7'b000000_1;

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       mrd;
      logic [4:0] rd;
      logic       req;
      logic       rdy;
      logic       mdu;
      logic       red;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[12];

   logic [6:0] op_list[10];

   function automatic logic [6:0] outs();
      return {bus.o_pc_stall, bus.o_if_id_stall, bus.o_if_id_flush,
              bus.o_id_ex_stall, bus.o_id_ex_flush, bus.o_ex_wb_stall,
              bus.o_mdu_busy};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.i_id_opcode    = OPCODE_OP_IMM;
      bus.i_id_rs1       = 5'd0;
      bus.i_id_rs2       = 5'd0;
      bus.i_ex_mem_read  = 1'b0;
      bus.i_ex_rd        = 5'd0;
      bus.i_ex_mem_req   = 1'b0;
      bus.i_dmem_ready   = 1'b0;
      bus.i_ex_mdu_start = 1'b0;
      bus.i_mdu_done     = 1'b0;
      bus.i_ex_redirect  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst_n = 1'b0;
      idle();
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   // ---------------- reference model ----------------
   // Tracks what the pipeline is waiting on, how long a memory wait has run,
   // the sticky flag and the stall tally.
   int          m_wait;      // 0 = nothing, 1 = data memory, 2 = MUL/DIV
   int          m_mem_len;
   bit          m_flag;
   logic [31:0] m_cnt;

   function automatic bit ref_rs1(input logic [6:0] op);
      return !(op == 7'h6F || op == 7'h37 || op == 7'h17);
   endfunction

   function automatic bit ref_rs2(input logic [6:0] op);
      return (op == 7'h33 || op == 7'h23 || op == 7'h63);
   endfunction

   function automatic logic [6:0] ref_outs();
      bit lu, mem_hold;
      if (!i_rst_n) return O_NONE;
      lu = bus.i_ex_mem_read && bus.i_ex_rd != 0 &&
           ((ref_rs1(bus.i_id_opcode) && bus.i_ex_rd == bus.i_id_rs1) ||
            (ref_rs2(bus.i_id_opcode) && bus.i_ex_rd == bus.i_id_rs2));
      mem_hold = bus.i_ex_mem_req && !bus.i_dmem_ready;
      if (m_wait == 1) return O_FREEZE;
      if (m_wait == 2) return bus.i_mdu_done ? O_MDUD : O_MDUW;
      if (mem_hold || bus.i_ex_mdu_start) return O_FREEZE;
      if (bus.i_ex_redirect) return O_RED;
      if (lu) return O_LU;
      return O_NONE;
   endfunction

   task automatic ref_step(input logic [6:0] exp_o);
      if (!i_rst_n) begin
         m_wait = 0; m_mem_len = 0; m_flag = 0; m_cnt = 32'd0;
      end else begin
         if (exp_o[6]) m_cnt = m_cnt + 32'd1;
         if (m_wait == 0) begin
            if (bus.i_ex_mem_req && !bus.i_dmem_ready) m_wait = 1;
            else if (bus.i_ex_mdu_start) m_wait = 2;
         end else if (m_wait == 1) begin
            m_mem_len = m_mem_len + 1;
            if (m_mem_len >= TB_TIMEOUT) m_flag = 1;
            if (bus.i_dmem_ready) begin
               m_wait = 0; m_mem_len = 0;
            end
         end else begin
            if (bus.i_mdu_done) m_wait = 0;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0;
      idle();

      op_list = '{OPCODE_R, OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
                  OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC, OPCODE_SYSTEM};

      //          name            op             rs1   rs2   mrd  rd    req  rdy  mdu  red  exp
      vecs[0]  = '{"lu_rs1",      OPCODE_R,      5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
      vecs[1]  = '{"lu_rd0",      OPCODE_R,      5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[2]  = '{"lu_lui",      OPCODE_LUI,    5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[3]  = '{"lu_store_rs2",OPCODE_STORE,  5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
      vecs[4]  = '{"lu_imm_rs2",  OPCODE_OP_IMM, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[5]  = '{"lu_jal",      OPCODE_JAL,    5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[6]  = '{"no_load",     OPCODE_R,      5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[7]  = '{"redir_lu",    OPCODE_R,      5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, O_RED};
      vecs[8]  = '{"freeze_mem",  OPCODE_R,      5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, O_FREEZE};
      vecs[9]  = '{"mem_ready",   OPCODE_R,      5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, O_NONE};
      vecs[10] = '{"freeze_mdu",  OPCODE_R,      5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, O_FREEZE};
      vecs[11] = '{"lu_branch",   OPCODE_BRANCH, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};

      // Outputs forced low while reset is held, even with freeze inputs
      @(negedge i_clk);
      bus.i_ex_mem_req   = 1'b1;
      bus.i_ex_mdu_start = 1'b1;
      bus.i_ex_redirect  = 1'b1;
      #1 check("reset_forced_low", 64'(outs()), 64'(O_NONE));
      do_reset();
      @(negedge i_clk);
      check("reset_outs", 64'(outs()), 64'(O_NONE));
      check("reset_cnt", 64'(bus.o_stall_cycles), 64'd0);
      check("reset_flag", 64'(bus.o_mem_timeout), 64'd0);

      // ---------------- decision table ----------------
      for (int i = 0; i < 12; i++) begin
         do_reset();
         @(negedge i_clk);
         bus.i_id_opcode    = vecs[i].op;
         bus.i_id_rs1       = vecs[i].rs1;
         bus.i_id_rs2       = vecs[i].rs2;
         bus.i_ex_mem_read  = vecs[i].mrd;
         bus.i_ex_rd        = vecs[i].rd;
         bus.i_ex_mem_req   = vecs[i].req;
         bus.i_dmem_ready   = vecs[i].rdy;
         bus.i_ex_mdu_start = vecs[i].mdu;
         bus.i_ex_redirect  = vecs[i].red;
         #1 check(vecs[i].name, 64'(outs()), 64'(vecs[i].exp));
      end

      // Load-use lasts exactly one cycle once the load leaves EX
      do_reset();
      @(negedge i_clk);
      bus.i_id_opcode = OPCODE_R; bus.i_id_rs1 = 5'd5;
      bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = 5'd5;
      #1 check("lu_cycle0", 64'(outs()), 64'(O_LU));
      @(negedge i_clk);
      bus.i_ex_mem_read = 1'b0; bus.i_ex_rd = 5'd0;
      #1 check("lu_cycle1", 64'(outs()), 64'(O_NONE));

      // ---------------- memory wait: 3 not-ready cycles ----------------
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         bus.i_ex_mem_req = (c < 4);
         bus.i_dmem_ready = (c >= 3);
         #1 check($sformatf("memwait_c%0d", c), 64'(outs()), 64'((c < 4) ? O_FREEZE : O_NONE));
      end
      check("memwait_cnt", 64'(bus.o_stall_cycles), 64'd4);
      check("memwait_noflag", 64'(bus.o_mem_timeout), 64'd0);

      // ---------------- timeout ----------------
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge i_clk);
         bus.i_ex_mem_req = (c < 11);
         bus.i_dmem_ready = (c >= 10);
         #1 check($sformatf("timeout_c%0d", c), 64'(bus.o_mem_timeout), 64'((c >= 5) ? 1 : 0));
      end
      check("timeout_back_run", 64'(outs()), 64'(O_NONE));
      do_reset();
      @(negedge i_clk);
      #1 check("timeout_cleared", 64'(bus.o_mem_timeout), 64'd0);

      // ---------------- MDU with held redirect ----------------
      do_reset();
      for (int c = 0; c < 9; c++) begin
         logic [6:0] e;
         @(negedge i_clk);
         bus.i_ex_mdu_start = (c <= 6);
         bus.i_mdu_done     = (c == 6);
         bus.i_ex_redirect  = (c <= 7);
         e = (c == 0) ? O_FREEZE : (c < 6) ? O_MDUW : (c == 6) ? O_MDUD :
             (c == 7) ? O_RED : O_NONE;
         #1 check($sformatf("mdu_c%0d", c), 64'(outs()), 64'(e));
      end
      check("mdu_cnt", 64'(bus.o_stall_cycles), 64'd6);

      // ---------------- reset inside MDU wait ----------------
      do_reset();
      @(negedge i_clk);
      bus.i_ex_mdu_start = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      #1 check("rstmid_busy", 64'(outs()), 64'(O_MDUW));
      i_rst_n = 1'b0;
      #1 check("rstmid_forced", 64'(outs()), 64'(O_NONE));
      @(negedge i_clk);
      i_rst_n = 1'b1;
      idle();
      #1 check("rstmid_after", 64'(outs()), 64'(O_NONE));
      check("rstmid_cnt", 64'(bus.o_stall_cycles), 64'd0);

      // ---------------- randomized traffic vs. model ----------------
      do_reset();
      m_wait = 0; m_mem_len = 0; m_flag = 0; m_cnt = 32'd0;
      for (int c = 0; c < 600; c++) begin
         logic [6:0] e;
         @(negedge i_clk);
         i_rst_n            = ($urandom_range(0, 99) >= 2);
         bus.i_id_opcode    = op_list[$urandom_range(0, 9)];
         bus.i_id_rs1       = 5'($urandom_range(0, 3));
         bus.i_id_rs2       = 5'($urandom_range(0, 3));
         bus.i_ex_mem_read  = ($urandom_range(0, 1) == 1);
         bus.i_ex_rd        = 5'($urandom_range(0, 3));
         bus.i_ex_mem_req   = ($urandom_range(0, 9) < 3);
         bus.i_dmem_ready   = ($urandom_range(0, 9) < 4);
         bus.i_ex_mdu_start = ($urandom_range(0, 9) < 1);
         bus.i_mdu_done     = ($urandom_range(0, 3) == 0);
         bus.i_ex_redirect  = ($urandom_range(0, 4) == 0);
         #1;
         e = ref_outs();
         check("rnd_outs", 64'(outs()), 64'(e));
         check("rnd_cnt", 64'(bus.o_stall_cycles), 64'(m_cnt));
         check("rnd_flag", 64'(bus.o_mem_timeout), 64'(m_flag));
         @(posedge i_clk);
         ref_step(e);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
